// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes: LANES combinational S-boxes substitute the 16 state bytes over 16/LANES cycles.
// Optional macro AES_SUB_BYTES_SHIFT_ROWS_EN fuses ShiftRows into out_data.

module aes_sub_bytes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  logic [7:0] x2_s, x3_s, x12_s, x15_s, x240_s, inv_s;

  // Inverse in GF(2^8) as x^254 (maps 0 to 0), then the AES affine transform.
  always_comb begin
    x2_s   = gf_mul(a_i, a_i);
    x3_s   = gf_mul(x2_s, a_i);
    x12_s  = gf_mul(gf_mul(x3_s, x3_s), gf_mul(x3_s, x3_s));
    x15_s  = gf_mul(x12_s, x3_s);
    x240_s = gf_mul(x15_s, x15_s);
    x240_s = gf_mul(x240_s, x240_s);
    x240_s = gf_mul(x240_s, x240_s);
    x240_s = gf_mul(x240_s, x240_s);
    inv_s  = gf_mul(x240_s, gf_mul(x12_s, x2_s));
    y_o    = inv_s ^ rotl8(inv_s, 1) ^ rotl8(inv_s, 2) ^ rotl8(inv_s, 3) ^ rotl8(inv_s, 4) ^ 8'h63;
  end

endmodule

module aes_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [KW-1:0] k_q;
  logic [7:0]  work_q [16];
  logic [7:0]  work_d [16];
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [3:0]  base_s;
  logic [3:0]  lane_idx_s [LANES];
  logic [7:0]  sbox_in_s  [LANES];
  logic [7:0]  sbox_out_s [LANES];

  // Group k covers bytes k*LANES .. k*LANES+LANES-1; the 4-bit index can never leave 0..15.
  always_comb begin
    base_s = 4'(k_q * LANES);
    for (int l = 0; l < LANES; l++) begin
      lane_idx_s[l] = base_s + 4'(l);
      sbox_in_s[l]  = work_q[lane_idx_s[l]];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sub_bytes_sbox u_sbox (
      .a_i (sbox_in_s[g]),
      .y_o (sbox_out_s[g])
    );
  end

  // Working register with the current group replaced by S-box outputs.
  always_comb begin
    work_d = work_q;
    for (int l = 0; l < LANES; l++) begin
      work_d[lane_idx_s[l]] = sbox_out_s[l];
    end
  end

  // Control FSM with registered handshake outputs and the working register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        work_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            for (int i = 0; i < 16; i++) begin
              work_q[i] <= in_data[127 - 8*i -: 8];
            end
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          if (k_q == KW'(N - 1)) begin
            k_q         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          k_q         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
  // Byte (r,c) of the output takes substituted byte (r,(c+r) mod 4); index is r+4c.
  always_comb begin
    out_data = 128'h0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        out_data[127 - 8*(r + 4*c) -: 8] = work_q[r + 4*((c + r) % 4)];
      end
    end
  end
`else
  // Plain SubBytes result, packed back into column-major order.
  always_comb begin
    out_data = 128'h0;
    for (int i = 0; i < 16; i++) begin
      out_data[127 - 8*i -: 8] = work_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Directed bench for aes_sub_bytes_iter: one instance per legal LANES value (1,2,4,8,16) on a shared clock.
// Expected values follow AES_SUB_BYTES_SHIFT_ROWS_EN when it is defined.

module tb_aes_sub_bytes_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     [5];
  logic         in_valid  [5];
  logic         in_ready  [5];
  logic [127:0] in_data   [5];
  logic         out_valid [5];
  logic         out_ready [5];
  logic [127:0] out_data  [5];
  logic         busy      [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SWEEP_IN = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
  localparam logic [127:0] FIPS_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] SWEEP_OUT = 128'h63fcac161bee28c3c4c193f54b8233ea;
`else
  localparam logic [127:0] FIPS_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SWEEP_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROWS[b[7:4]];
    return row[127 - 8*b[3:0] -: 8];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [7:0]   s [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox_ref(d[127 - 8*i -: 8]);
    o = 128'h0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
        o[127 - 8*(r + 4*c) -: 8] = s[r + 4*((c + r) % 4)];
`else
        o[127 - 8*(r + 4*c) -: 8] = s[r + 4*c];
`endif
      end
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the instance idle; returns just after a negedge, idle again.
  task automatic run_block(input int idx, input logic [127:0] data, input logic [127:0] exp,
                           input int exp_lat, input string tag);
    int lat;
    in_valid[idx]  = 1'b1;
    in_data[idx]   = data;
    out_ready[idx] = 1'b0;
    chk({tag, "_in_ready"}, 128'(in_ready[idx]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    in_data[idx]  = ~data;
    if (exp_lat > 1) begin
      chk({tag, "_busy"}, 128'({busy[idx], in_ready[idx]}), 128'b10);
    end else begin
      chk({tag, "_busy"}, 128'(busy[idx]), 128'd1);
    end
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_data"}, out_data[idx], exp);
    chk({tag, "_done_flags"}, 128'({busy[idx], in_ready[idx]}), 128'b00);
    out_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[idx] = 1'b0;
    chk({tag, "_idle_flags"}, 128'({out_valid[idx], in_ready[idx]}), 128'b01);
  endtask

  initial begin
    logic [127:0] blk [8];
    logic [127:0] held;
    int lat, acc, got, last, cyc;
    logic seen;

    for (int i = 0; i < 5; i++) begin
      rst_n[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = 128'h0;
    end
    in_valid[2] = 1'b1;
    in_data[2]  = FIPS_IN;

    // Reset held for three edges while upstream asserts valid.
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 128'(in_ready[2]), 128'd1);
    chk("reset_out_valid", 128'(out_valid[2]), 128'd0);
    chk("reset_busy", 128'(busy[2]), 128'd0);
    chk("reset_out_data", out_data[2], 128'h0);
    for (int i = 0; i < 5; i++) rst_n[i] = 1'b1;

    // First accept on the edge after release: FIPS round-1 vector.
    run_block(2, FIPS_IN, FIPS_OUT, 4, "fips");

    // Byte-map sweep across every legal LANES value.
    for (int g = 0; g < 5; g++) begin
      run_block(g, SWEEP_IN, SWEEP_OUT, 16 >> g, $sformatf("sweep_l%0d", 1 << g));
    end

    // Backpressure: result held for 10 cycles while a new block waits.
    in_valid[2] = 1'b1;
    in_data[2]  = SWEEP_IN;
    @(posedge clk);
    @(negedge clk);
    in_data[2] = FIPS_IN;
    lat = 0;
    while (!out_valid[2] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 128'(lat), 128'd4);
    held = out_data[2];
    chk("bp_first_data", held, SWEEP_OUT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data[2], SWEEP_OUT);
      chk("bp_hold_flags", 128'({out_valid[2], in_ready[2], busy[2]}), 128'b100);
    end
    out_ready[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[2] = 1'b0;
    chk("bp_release_flags", 128'({out_valid[2], in_ready[2]}), 128'b01);
    run_block(2, FIPS_IN, FIPS_OUT, 4, "bp_next");

    // Reset while the LANES=2 instance is at k=2 discards the block.
    in_valid[1] = 1'b1;
    in_data[1]  = FIPS_IN;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    chk("midrst_flags", 128'({busy[1], out_valid[1], in_ready[1]}), 128'b001);
    chk("midrst_out_data", out_data[1], 128'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | out_valid[1];
      @(negedge clk);
    end
    chk("midrst_no_output", 128'(seen), 128'd0);
    run_block(1, 128'h0, {16{8'h63}}, 8, "midrst_zero");

    // Back-to-back random blocks with valid and ready held high.
    for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready[2] = 1'b1;
    in_valid[2]  = 1'b1;
    acc = 0; got = 0; last = 0; cyc = 0;
    while (got < 8 && cyc < 200) begin
      if (acc == 8) in_valid[2] = 1'b0;
      if (in_ready[2] && acc < 8) begin
        in_data[2] = blk[acc];
        if (acc > 0) chk("b2b_period", 128'(cyc - last), 128'd6);
        last = cyc;
        acc++;
      end
      if (out_valid[2]) begin
        chk($sformatf("b2b_data%0d", got), out_data[2], model(blk[got]));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", 128'(got), 128'd8);
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
